dcache_refill_ctrl: RTL and testbench
=====================================

Name: dcache_refill_ctrl

Overview:
- Miss/refill controller between the direct-mapped data cache (memory stage) and the backing data memory.
- On a read miss: stalls the pipeline, fetches the word from data memory over a req/ready handshake, refills the cache set and returns the word to ReadDataW.
- On every store: performs a write-through to data memory and stalls until it is accepted.
- Keeps a saturating read-miss counter.

Parameters:
- NUM_SET, 8, number of cache sets (power of 2); SET_W = $clog2(NUM_SET), TAG_W = 30 - SET_W (27 at default).
- CNT_W, 16, width of the read-miss counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- MemReadM  in  1  load in memory stage
- MemWriteM  in  1  store in memory stage
- ALUResultM  in  32  memory address; tag [31:32-TAG_W], set [SET_W+1:2], offset [1:0] ignored
- WriteDataM  in  32  store data
- Hit  in  1  cache hit for ALUResultM
- StallM  out  1  hold the memory stage and everything upstream
- FillEn  out  1  one-cycle cache refill strobe
- FillSet  out  SET_W  refill set index
- FillTag  out  TAG_W  refill tag
- FillData  out  32  refill word
- RefillValid  out  1  ReadDataW must take RefillData this cycle instead of cache data
- RefillData  out  32  fetched word
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00} captured)
- mem_wdata  out  32  write data
- mem_ready  in  1  memory accepts/completes the request this cycle
- mem_rdata  in  32  read data, valid when mem_ready=1 on a read
- MissCount  out  CNT_W  saturating read-miss count

Behaviour:
- States: IDLE, RD_WAIT, FILL, WR_WAIT. Pipeline advances on any edge where StallM=0.
- Reset (sync, rst=1 at posedge) returns to IDLE and clears addr/data registers and MissCount.
  - Outputs after reset: StallM=0, FillEn=0, RefillValid=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, FillData=RefillData=0, MissCount=0.
  - rst dominates every state, including mid-transaction. A mem_ready arriving after reset is ignored.
- IDLE:
  - MemWriteM=1 (priority over read): capture address and WriteDataM; StallM=1 combinationally this cycle; next state WR_WAIT.
  - Else MemReadM=1 && Hit=0: capture address; StallM=1 combinationally; MissCount+1 (holds at all-ones); next state RD_WAIT.
  - Else StallM=0. mem_ready is ignored in IDLE.
- RD_WAIT:
  - mem_req=1, mem_we=0, mem_addr stable; StallM=1.
  - On mem_ready=1: register mem_rdata; next state FILL.
  - Minimum miss penalty is 2 stall cycles (entry cycle plus RD_WAIT with immediate ready).
- FILL (exactly 1 cycle):
  - mem_req=0, StallM=0, FillEn=1.
  - FillSet/FillTag come from the captured address; FillData=RefillData=captured word; RefillValid=1.
  - Next state IDLE. The retired load is not re-evaluated.
- WR_WAIT:
  - mem_req=1, mem_we=1, mem_addr/mem_wdata stable.
  - StallM = !mem_ready, so the store retires in the ready cycle; on mem_ready=1 next state IDLE.
  - The cache performs its own store update from MemWriteM; this block never drives FillEn for stores.
- FillEn and RefillValid are 0 in every state except FILL.
- mem_addr/mem_wdata hold their last captured value outside transactions.
- A new miss in the cycle immediately after FILL or WR_WAIT completion is accepted normally (back-to-back).
- MemReadM/MemWriteM/ALUResultM changes during RD_WAIT/WR_WAIT are ignored; the pipeline holds them stable under stall regardless.

Decomposition:
- Package dcache_pkg holds:
  - state enum;
  - functions addr_tag() and addr_set() parameterised by SET_W;
  - localparams SET_W/TAG_W derived from NUM_SET.
- Sub-module sat_counter (width CNT_W, inc, clear) for MissCount. Everything else stays in one always_ff plus one always_comb.

Test Plan:
- Reset: assert rst 2 cycles mid-RD_WAIT -> next cycle state IDLE, mem_req=0, StallM=0, MissCount=0; a late mem_ready=1 is ignored.
- Read miss, memory ready after 3 cycles:
  - Stimulus: MemReadM=1, Hit=0, ALUResultM=0x0000_0034, mem_rdata=0xDEAD_BEEF.
  - Expect: mem_addr=0x34, StallM high 4 cycles, then FILL with FillSet=5, FillTag=0x1, FillData=RefillData=0xDEADBEEF, RefillValid=1, MissCount=1.
- Store write-through:
  - Stimulus: MemWriteM=1, ALUResultM=0x103, WriteDataM=0x1234_5678, mem_ready on 2nd WR_WAIT cycle.
  - Expect: mem_we=1, mem_addr=0x100, mem_wdata=0x12345678, StallM=1 for 2 cycles and 0 in the ready cycle, FillEn never asserted.
- Hit path: MemReadM=1, Hit=1 for 10 cycles -> StallM=0, mem_req=0, MissCount unchanged.
- Back-to-back: read miss to 0x20 followed immediately by read miss to 0x40 (both ready immediate) -> two FILL pulses 3 cycles apart, MissCount=2.
- Saturation and priority: CNT_W=4, 17 read misses -> MissCount=0xF; then MemReadM=1, MemWriteM=1, Hit=0 -> write transaction taken, MissCount unchanged.

Source files
------------

// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared types and address helpers for the data-cache refill controller.
// Address layout: tag | set | 2-bit byte offset.
package dcache_pkg;

    localparam int DC_NUM_SET = 8;
    localparam int DC_SET_W   = $clog2(DC_NUM_SET);
    localparam int DC_TAG_W   = 30 - DC_SET_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_FILL    = 2'd2,
        S_WR_WAIT = 2'd3
    } dc_state_e;

    // Results are right-aligned; callers size-cast them to SET_W/TAG_W.
    function automatic logic [31:0] addr_set(input logic [31:0] a, input int set_w);
        return (a >> 2) & ((32'd1 << set_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int set_w);
        return a >> (set_w + 2);
    endfunction

endpackage

// File: rtl/dcache_refill_ctrl_sat_counter.sv
// Saturating up-counter; clear has priority over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clear)
            r_count <= '0;
        else if (i_inc && (r_count != {CNT_W{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Read-miss refill and store write-through controller for the direct-mapped
// data cache, with a saturating read-miss counter.
module dcache_refill_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_SET = DC_NUM_SET,
    parameter int CNT_W   = 16,
    localparam int SET_W  = $clog2(NUM_SET),
    localparam int TAG_W  = 30 - SET_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic [31:0]      ALUResultM,
    input  logic [31:0]      WriteDataM,
    input  logic             Hit,
    output logic             StallM,
    output logic             FillEn,
    output logic [SET_W-1:0] FillSet,
    output logic [TAG_W-1:0] FillTag,
    output logic [31:0]      FillData,
    output logic             RefillValid,
    output logic [31:0]      RefillData,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] MissCount
);

    dc_state_e   r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_req;
    logic        r_we;
    logic        r_fill;
    logic        w_rd_miss;
    logic        w_miss_inc;

    // Stores take priority, so a load+store in the same cycle is not a miss.
    assign w_rd_miss  = !MemWriteM && MemReadM && !Hit;
    assign w_miss_inc = !rst && (r_state == S_IDLE) && w_rd_miss;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_fill  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_fill <= 1'b0;
                    if (MemWriteM) begin
                        r_addr  <= ALUResultM & 32'hFFFF_FFFC;
                        r_wdata <= WriteDataM;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_state <= S_WR_WAIT;
                    end else if (w_rd_miss) begin
                        r_addr  <= ALUResultM & 32'hFFFF_FFFC;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_ready) begin
                        r_rdata <= mem_rdata;
                        r_req   <= 1'b0;
                        r_fill  <= 1'b1;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_fill  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_WR_WAIT: begin
                    if (mem_ready) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                    r_fill  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The stall must rise in the same cycle the miss/store is seen and drop
    // in the write-accept cycle, so it cannot be registered.
    always_comb begin
        StallM = 1'b0;
        case (r_state)
            S_IDLE:    StallM = MemWriteM || w_rd_miss;
            S_RD_WAIT: StallM = 1'b1;
            S_FILL:    StallM = 1'b0;
            S_WR_WAIT: StallM = !mem_ready;
            default:   StallM = 1'b0;
        endcase
    end

    assign FillEn      = r_fill;
    assign RefillValid = r_fill;
    assign FillSet     = SET_W'(addr_set(r_addr, SET_W));
    assign FillTag     = TAG_W'(addr_tag(r_addr, SET_W));
    assign FillData    = r_rdata;
    assign RefillData  = r_rdata;
    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk     (clk),
        .i_clear (rst),
        .i_inc   (w_miss_inc),
        .o_count (MissCount)
    );

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed self-checking bench for dcache_refill_ctrl (CNT_W=4 to reach saturation).
module tb_dcache_refill_ctrl;

    localparam int SET_W = 3;
    localparam int TAG_W = 27;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             MemReadM, MemWriteM, Hit;
    logic [31:0]      ALUResultM, WriteDataM;
    logic             StallM, FillEn, RefillValid;
    logic [SET_W-1:0] FillSet;
    logic [TAG_W-1:0] FillTag;
    logic [31:0]      FillData, RefillData;
    logic             mem_req, mem_we, mem_ready;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [CNT_W-1:0] MissCount;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    dcache_refill_ctrl #(.NUM_SET(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .Hit(Hit),
        .StallM(StallM), .FillEn(FillEn), .FillSet(FillSet), .FillTag(FillTag),
        .FillData(FillData), .RefillValid(RefillValid), .RefillData(RefillData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .MissCount(MissCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a read miss from IDLE; memory answers on the nw-th RD_WAIT cycle.
    // Returns in the FILL cycle with the stall-cycle count.
    task automatic rd_miss(input logic [31:0] a, input logic [31:0] d, input int nw,
                           output int stalls);
        MemReadM = 1'b1; MemWriteM = 1'b0; Hit = 1'b0;
        ALUResultM = a; mem_rdata = d; mem_ready = 1'b0;
        stalls = 0;
        #1;
        if (StallM) stalls++;
        tick();
        for (int k = 0; k < nw; k++) begin
            mem_ready = (k == nw - 1);
            #1;
            if (StallM) stalls++;
            tick();
        end
        mem_ready = 1'b0;
        #1;
    endtask

    int s;
    int c_fill1;

    initial begin
        rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; Hit = 1'b0;
        ALUResultM = '0; WriteDataM = '0; mem_ready = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(StallM), 32'd0);
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_fill",  32'(FillEn), 32'd0);
        chk("rst_rv",    32'(RefillValid), 32'd0);
        chk("rst_rdata", RefillData, 32'd0);
        chk("rst_cnt",   32'(MissCount), 32'd0);

        // read miss, memory ready on the 3rd RD_WAIT cycle
        MemReadM = 1'b1; Hit = 1'b0; ALUResultM = 32'h34;
        tick();
        chk("rd_req",  32'(mem_req), 32'd1);
        chk("rd_we",   32'(mem_we), 32'd0);
        chk("rd_addr", mem_addr, 32'h34);
        chk("rd_cnt",  32'(MissCount), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        rd_miss(32'h34, 32'hDEAD_BEEF, 3, s);
        chk("rd_stalls", 32'(s), 32'd4);
        chk("rd_fillen", 32'(FillEn), 32'd1);
        chk("rd_set",    32'(FillSet), 32'd5);
        chk("rd_tag",    32'(FillTag), 32'd1);
        chk("rd_fdata",  FillData, 32'hDEAD_BEEF);
        chk("rd_rdata",  RefillData, 32'hDEAD_BEEF);
        chk("rd_rvalid", 32'(RefillValid), 32'd1);
        chk("rd_fstall", 32'(StallM), 32'd0);
        chk("rd_freq",   32'(mem_req), 32'd0);
        chk("rd_fcnt",   32'(MissCount), 32'd1);
        MemReadM = 1'b0;
        tick();
        chk("rd_post_fill", 32'(FillEn), 32'd0);
        chk("rd_post_rv",   32'(RefillValid), 32'd0);

        // store write-through, accepted on the 2nd WR_WAIT cycle
        MemWriteM = 1'b1; ALUResultM = 32'h103; WriteDataM = 32'h1234_5678;
        #1;
        chk("wr_entry_stall", 32'(StallM), 32'd1);
        tick();
        chk("wr_req",    32'(mem_req), 32'd1);
        chk("wr_we",     32'(mem_we), 32'd1);
        chk("wr_addr",   mem_addr, 32'h100);
        chk("wr_wdata",  mem_wdata, 32'h1234_5678);
        chk("wr_stall1", 32'(StallM), 32'd1);
        chk("wr_fill1",  32'(FillEn), 32'd0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("wr_stall_rdy", 32'(StallM), 32'd0);
        chk("wr_fill2",     32'(FillEn), 32'd0);
        tick();
        MemWriteM = 1'b0; mem_ready = 1'b0;
        #1;
        chk("wr_done_req",  32'(mem_req), 32'd0);
        chk("wr_done_fill", 32'(FillEn), 32'd0);
        chk("wr_hold_addr", mem_addr, 32'h100);
        chk("wr_cnt",       32'(MissCount), 32'd1);

        // hit path
        MemReadM = 1'b1; Hit = 1'b1; ALUResultM = 32'h48;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("hit_stall", 32'(StallM), 32'd0);
            chk("hit_req",   32'(mem_req), 32'd0);
            tick();
        end
        chk("hit_cnt", 32'(MissCount), 32'd1);

        // reset mid-RD_WAIT, then a late mem_ready
        Hit = 1'b0; ALUResultM = 32'h80;
        tick();
        chk("rrst_req_pre", 32'(mem_req), 32'd1);
        chk("rrst_cnt_pre", 32'(MissCount), 32'd2);
        rst = 1'b1; MemReadM = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rrst_req",   32'(mem_req), 32'd0);
        chk("rrst_stall", 32'(StallM), 32'd0);
        chk("rrst_cnt",   32'(MissCount), 32'd0);
        chk("rrst_addr",  mem_addr, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ready = 1'b0;
        #1;
        chk("late_rdy_fill",  32'(FillEn), 32'd0);
        chk("late_rdy_req",   32'(mem_req), 32'd0);
        chk("late_rdy_rdata", RefillData, 32'd0);

        // back-to-back misses
        rd_miss(32'h20, 32'h0000_00A1, 1, s);
        chk("b2b_stalls1", 32'(s), 32'd2);
        chk("b2b_fill1",   32'(FillEn), 32'd1);
        chk("b2b_tag1",    32'(FillTag), 32'd1);
        c_fill1 = cyc;
        tick();
        rd_miss(32'h40, 32'h0000_00B2, 1, s);
        chk("b2b_fill2",  32'(FillEn), 32'd1);
        chk("b2b_gap",    32'(cyc - c_fill1), 32'd3);
        chk("b2b_set2",   32'(FillSet), 32'd0);
        chk("b2b_tag2",   32'(FillTag), 32'd2);
        chk("b2b_data2",  RefillData, 32'h0000_00B2);
        chk("b2b_cnt",    32'(MissCount), 32'd2);
        MemReadM = 1'b0;
        tick();

        // load+store in the same cycle: store wins, no miss counted
        MemReadM = 1'b1; MemWriteM = 1'b1; Hit = 1'b0;
        ALUResultM = 32'h200; WriteDataM = 32'hCAFE_F00D;
        #1;
        chk("pri_stall", 32'(StallM), 32'd1);
        tick();
        chk("pri_we",    32'(mem_we), 32'd1);
        chk("pri_addr",  mem_addr, 32'h200);
        chk("pri_wdata", mem_wdata, 32'hCAFE_F00D);
        mem_ready = 1'b1;
        tick();
        MemReadM = 1'b0; MemWriteM = 1'b0; mem_ready = 1'b0;
        #1;
        chk("pri_cnt",  32'(MissCount), 32'd2);
        chk("pri_fill", 32'(FillEn), 32'd0);

        // saturation: 15 more misses, 17 in all since the last reset
        for (int i = 0; i < 15; i++) begin
            rd_miss(32'h300 + 32'(i * 4), 32'(i), 1, s);
            MemReadM = 1'b0;
            tick();
            if (i == 11) chk("sat_cnt14", 32'(MissCount), 32'hE);
        end
        chk("sat_cnt", 32'(MissCount), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
